// File: rtl/cby_param_ccff_pkg.sv
// Shared defaults and select-width helper for the Y-channel connection block.
package cby_param_ccff_pkg;

  localparam int DEF_CHAN_WIDTH   = 9;
  localparam int DEF_NUM_IPIN     = 7;
  localparam int DEF_MUX_SIZE     = 6;
  localparam int DEF_TRACK_STRIDE = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cby_param_ccff_if.sv
// Track, configuration-chain and pin signals of the connection block.
interface cby_param_ccff_if
  import cby_param_ccff_pkg::*;
#(
  parameter int CHAN_WIDTH = DEF_CHAN_WIDTH,
  parameter int NUM_IPIN   = DEF_NUM_IPIN
) ();

  logic [CHAN_WIDTH-1:0] chany_bottom_in;
  logic [CHAN_WIDTH-1:0] chany_top_in;
  logic [CHAN_WIDTH-1:0] chany_bottom_out;
  logic [CHAN_WIDTH-1:0] chany_top_out;
  logic                  ccff_head;
  logic                  ccff_en;
  logic                  cfg_commit;
  logic [NUM_IPIN-1:0]   ipin_out;
  logic                  ccff_tail;
  logic                  cfg_done;
  logic                  cfg_valid;

  modport master (
    output chany_bottom_in, chany_top_in, ccff_head, ccff_en, cfg_commit,
    input  chany_bottom_out, chany_top_out, ipin_out, ccff_tail, cfg_done, cfg_valid
  );

  modport slave (
    input  chany_bottom_in, chany_top_in, ccff_head, ccff_en, cfg_commit,
    output chany_bottom_out, chany_top_out, ipin_out, ccff_tail, cfg_done, cfg_valid
  );

endinterface

// File: rtl/cby_ipin_mux.sv
// One grid-pin selector: combinational, forced low when disabled or the select is out of range.
module cby_ipin_mux #(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = 3
) (
  input  logic [MUX_SIZE-1:0] data,
  input  logic [SEL_W-1:0]    sel,
  input  logic                enable,
  output logic                pin
);

  always_comb begin
    pin = 1'b0;
    if (enable) begin
      for (int i = 0; i < MUX_SIZE; i++) begin
        if (sel == SEL_W'(i)) pin = data[i];
      end
    end
  end

endmodule

// File: rtl/cby_param_ccff.sv
// Connection block: serial config chain with shadow/active selects; pins combinational from tracks,
// config takes effect one prog_clk edge after commit. No backpressure.
module cby_param_ccff
  import cby_param_ccff_pkg::*;
#(
  parameter int CHAN_WIDTH   = DEF_CHAN_WIDTH,
  parameter int NUM_IPIN     = DEF_NUM_IPIN,
  parameter int MUX_SIZE     = DEF_MUX_SIZE,
  parameter int TRACK_STRIDE = DEF_TRACK_STRIDE
) (
  input  logic             prog_clk,
  input  logic             prog_reset_n,
  cby_param_ccff_if.slave  bus
);

  localparam int SEL_W     = clog2(MUX_SIZE);
  localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
  localparam int CNT_W     = clog2(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain;
  logic [SEL_W-1:0]     active_sel [NUM_IPIN];
  logic [CNT_W-1:0]     cnt;
  logic                 tail;
  logic                 valid;
  logic [NUM_IPIN-1:0]  ipin;

  assign bus.chany_top_out    = bus.chany_bottom_in;
  assign bus.chany_bottom_out = bus.chany_top_in;

  // Commit samples the chain before any same-edge shift, so a commit+shift
  // activates the old contents and the counter restarts at one.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      chain <= '0;
      tail  <= 1'b0;
      cnt   <= '0;
      valid <= 1'b0;
      for (int k = 0; k < NUM_IPIN; k++) active_sel[k] <= '0;
    end else begin
      if (bus.ccff_en) begin
        chain <= {chain[CHAIN_LEN-2:0], bus.ccff_head};
        tail  <= chain[CHAIN_LEN-1];
      end
      if (bus.cfg_commit) begin
        for (int k = 0; k < NUM_IPIN; k++) active_sel[k] <= chain[k*SEL_W +: SEL_W];
        valid <= 1'b1;
        cnt   <= {{(CNT_W-1){1'b0}}, bus.ccff_en};
      end else if (bus.ccff_en && (cnt != CNT_W'(CHAIN_LEN))) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ccff_tail = tail;
  assign bus.cfg_valid = valid;
  assign bus.cfg_done  = (cnt == CNT_W'(CHAIN_LEN));

  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
    logic [MUX_SIZE-1:0] mux_data;

    for (genvar j = 0; j < MUX_SIZE/2; j++) begin : g_pair
      localparam int TRACK = (k + j*TRACK_STRIDE) % CHAN_WIDTH;
      assign mux_data[2*j]   = bus.chany_bottom_in[TRACK];
      assign mux_data[2*j+1] = bus.chany_top_in[TRACK];
    end

    cby_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .data   (mux_data),
      .sel    (active_sel[k]),
      .enable (valid),
      .pin    (ipin[k])
    );
  end

  assign bus.ipin_out = ipin;

endmodule

// File: doc/cby_param_ccff.md
CBY_PARAM_CCFF -- requirements
Module: cby_param_ccff

Interface
REQ-001 The block SHALL have parameter CHAN_WIDTH, default 9, giving tracks per direction.
REQ-002 The block SHALL have parameter NUM_IPIN, default 7, giving the number of grid pins driven.
REQ-003 The block SHALL have parameter MUX_SIZE, default 6, an even number of mux inputs per pin.
REQ-004 The block SHALL have parameter TRACK_STRIDE, default 4, giving the track spacing between mux input pairs.
REQ-005 The block SHALL derive SEL_W = clog2(MUX_SIZE) and CHAIN_LEN = NUM_IPIN*SEL_W.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset.
REQ-007 Port prog_clk, input, 1 bit: the configuration clock.
REQ-008 Port prog_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-009 Port chany_bottom_in, input, CHAN_WIDTH bits: tracks entering from the bottom.
REQ-010 Port chany_top_in, input, CHAN_WIDTH bits: tracks entering from the top.
REQ-011 Port chany_bottom_out and chany_top_out, outputs, CHAN_WIDTH bits each: pass-through tracks.
REQ-012 Port ccff_head, input, 1 bit: serial configuration data in.
REQ-013 Port ccff_en, input, 1 bit: shift enable.
REQ-014 Port cfg_commit, input, 1 bit: single-cycle pulse that activates shifted data.
REQ-015 Port ipin_out, output, NUM_IPIN bits: grid pin drivers.
REQ-016 Port ccff_tail, output, 1 bit: serial configuration data out.
REQ-017 Port cfg_done, output, 1 bit: set when exactly CHAIN_LEN or more bits have been shifted since the last commit or reset.
REQ-018 Port cfg_valid, output, 1 bit: set when at least one commit has occurred since reset.

Function
REQ-019 Pass-through SHALL be combinational: chany_top_out = chany_bottom_in and chany_bottom_out = chany_top_in.
REQ-020 On each prog_clk edge with ccff_en=1, the shift chain SHALL shift one position: ccff_head enters bit 0, and ccff_tail = chain[CHAIN_LEN-1], registered.
REQ-021 With ccff_en=0, the chain and the bit counter SHALL hold their values.
REQ-022 Pin k SHALL take its shadow select from chain bits [k*SEL_W +: SEL_W], LSB at the lower index.
REQ-023 On cfg_commit=1, all shadow selects SHALL be copied to the active select registers on that same edge. If shifting happens in the same cycle, the pre-shift chain value is captured.
REQ-024 Commit SHALL clear the bit counter and set cfg_valid. Commit together with shift SHALL leave the counter at 1.
REQ-025 The bit counter SHALL saturate at CHAIN_LEN, with cfg_done = (count == CHAIN_LEN).
REQ-026 Mux input 2j SHALL be chany_bottom_in[t_j] and input 2j+1 SHALL be chany_top_in[t_j], where t_j = (k + j*TRACK_STRIDE) mod CHAN_WIDTH and j = 0..MUX_SIZE/2-1.
REQ-027 ipin_out[k] SHALL equal mux input active_sel[k], combinational from the tracks.
REQ-028 ipin_out[k] SHALL be 0 when active_sel[k] >= MUX_SIZE or when cfg_valid = 0.

Reset
REQ-029 prog_reset_n=0 SHALL asynchronously clear the chain, active selects, counter, ccff_tail, cfg_done and cfg_valid; ipin_out is therefore 0.
REQ-030 Reset asserted mid-shift SHALL discard the partial configuration. The first edge after deassertion behaves as from a clean state.

Structure
REQ-031 A shared package SHALL hold the default parameter values and the clog2 select-width function.
REQ-032 Each pin's mux SHALL be one sub-module, cby_ipin_mux, parameterised by MUX_SIZE, and instantiated NUM_IPIN times by generate.
REQ-033 The chain, counter and commit logic SHALL remain in the top module.

Verification
REQ-034 Reset scenario: pulse reset, drive all tracks to 1 -> ipin_out=0, cfg_done=0, cfg_valid=0, ccff_tail=0.
REQ-035 Full-load scenario: shift 21 bits so pin 0 sel=4, then commit, then drive chany_bottom_in[8]=1 with other tracks 0 -> ipin_out[0]=1, cfg_done=1 before the commit, and cfg_done=0 after the commit.
REQ-036 Chain-through scenario: shift 42 bits, pattern 1,0,1,1,... -> ccff_tail replays the first 21 bits exactly 21 cycles later.
REQ-037 Invalid-select scenario: commit sel=7 on pin 3 with all tracks at 1 -> ipin_out[3]=0.
REQ-038 Simultaneous scenario: assert commit and ccff_en on the same edge -> the active value equals the pre-shift chain and the counter reads 1. Also, reset asserted after 10 shifts -> counter 0 and cfg_done=0.
